uart_frame_decoder: RTL



---
 rtl/uart_frame_pkg.sv | 21 ++
 rtl/uart_frame_timeout.sv | 31 +++
 rtl/uart_frame_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART `&&payload&&` string framing.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: DELIM character, DEFAULT_MAX_LEN (shared with the transmit-side
//   string handler), and the one-hot decoder state type.
package uart_frame_pkg;

  localparam logic [7:0] DELIM           = 8'h26;  // '&'
  localparam int         DEFAULT_MAX_LEN = 128;

  // One-hot so each status output (frame_vld/frame_err) is a single state flop.
  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_SOF1 = 6'b000010,
    ST_BODY = 6'b000100,
    ST_EOF1 = 6'b001000,
    ST_DONE = 6'b010000,
    ST_ERR  = 6'b100000
  } state_t;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter for the frame decoder; flags an expired partial frame.
// Latency: expire is combinational from the counter flop; the decoder registers it into ERR.
// Backpressure: none; clr (a received byte) always wins over expiry.
// Ports: sys_clk/sys_rst (sync, active-high); clr = byte seen; en = frame in progress;
//   expire = counter at TIMEOUT_CYC-1 with no byte this cycle.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr || !en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_frame_decoder.sv
// Extracts `&&payload&&` frames from the uart_rx byte stream into a flat byte buffer.
// Latency: frame_vld/frame_err pulse one cycle after the byte that completes/aborts a frame.
// Backpressure: none; every byte_vld is consumed, outputs are one-cycle strobes.
// Ports: sys_clk, sys_rst (sync, active-high); byte_data/byte_vld from uart_rx;
//   frame_data (byte k at [8k+7:8k]), frame_len, frame_vld, frame_err, busy.
// Optional: define UART_FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYC idle cycles.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN     = DEFAULT_MAX_LEN,
  parameter int         LEN_W       = 8,
  parameter logic [7:0] DELIM       = uart_frame_pkg::DELIM,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [7:0]         byte_data,
  input  logic               byte_vld,
  output logic [MAX_LEN*8-1:0] frame_data,
  output logic [LEN_W-1:0]   frame_len,
  output logic               frame_vld,
  output logic               frame_err,
  output logic               busy
);

  if (MAX_LEN < 2 || (2 ** LEN_W) <= MAX_LEN || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("uart_frame_decoder: illegal MAX_LEN/LEN_W/TIMEOUT_CYC");
  end

  state_t state_q, state_d;
  logic   clr_frame;  // SOF1 -> BODY: start a fresh payload
  logic   wr_one;     // BODY: store byte at frame_len
  logic   wr_two;     // EOF1: lone '&' was data, store '&' then byte
  logic   timeout;

  logic [LEN_W:0] len_ext;
  logic           is_delim;

  assign len_ext  = {1'b0, frame_len};
  assign is_delim = (byte_data == DELIM);

`ifdef UART_FRAME_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state_q == ST_SOF1) || (state_q == ST_BODY) || (state_q == ST_EOF1);

  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (byte_vld),
    .en      (tmo_en),
    .expire  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    clr_frame = 1'b0;
    wr_one    = 1'b0;
    wr_two    = 1'b0;
    case (state_q)
      // DONE/ERR last one cycle; a byte arriving then is treated as in IDLE.
      ST_IDLE, ST_DONE, ST_ERR: begin
        state_d = ST_IDLE;
        if (byte_vld && is_delim) state_d = ST_SOF1;
      end
      ST_SOF1: begin
        if (byte_vld) begin
          if (is_delim) begin
            state_d   = ST_BODY;
            clr_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_BODY: begin
        if (byte_vld) begin
          if (is_delim) begin
            state_d = ST_EOF1;
          end else if (len_ext == (LEN_W+1)'(MAX_LEN)) begin
            state_d = ST_ERR;
          end else begin
            wr_one = 1'b1;
          end
        end
      end
      ST_EOF1: begin
        if (byte_vld) begin
          if (is_delim) begin
            state_d = ST_DONE;
          end else if ((len_ext + (LEN_W+1)'(2)) > (LEN_W+1)'(MAX_LEN)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_BODY;
            wr_two  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_ERR;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      frame_data <= '0;
      frame_len  <= '0;
    end else begin
      state_q <= state_d;
      if (clr_frame) begin
        frame_data <= '0;
        frame_len  <= '0;
      end
      // Per-byte write enables keep the index decode explicit and width-clean.
      for (int k = 0; k < MAX_LEN; k++) begin
        if (wr_one && k == int'(frame_len))     frame_data[8*k +: 8] <= byte_data;
        if (wr_two && k == int'(frame_len))     frame_data[8*k +: 8] <= DELIM;
        if (wr_two && k == int'(frame_len) + 1) frame_data[8*k +: 8] <= byte_data;
      end
      if (wr_one) frame_len <= frame_len + LEN_W'(1);
      if (wr_two) frame_len <= frame_len + LEN_W'(2);
    end
  end

  assign frame_vld = (state_q == ST_DONE);
  assign frame_err = (state_q == ST_ERR);
  assign busy      = (state_q != ST_IDLE);

endmodule
